// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-RAM boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHK state usage).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } loader_state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 8 * LEN_BYTES;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_busy(input loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// byte_packer: packs a byte stream into 32-bit big-endian words.
// Ports:
//   clock, reset_n   clock and asynchronous active-low reset
//   clear            drop any partial word (index back to byte 0)
//   byte_en, byte_in accepted stream byte
//   word, word_valid completed word (held) and its one-cycle strobe
//   last_byte_c      combinational: the current byte completes a word
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte_c
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_idx;
  logic [31:0] r_shift;
  logic [31:0] r_word;
  logic        r_word_valid;

  assign last_byte_c = byte_en && (r_idx == LAST_IDX);
  assign word        = r_word;
  assign word_valid  = r_word_valid;

  // First byte ends up in [31:24] after four left shifts.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (clear) begin
        r_idx   <= '0;
        r_shift <= '0;
      end else if (byte_en) begin
        if (r_idx == LAST_IDX) begin
          r_word       <= {r_shift[23:0], byte_in};
          r_word_valid <= 1'b1;
          r_idx        <= '0;
          r_shift      <= '0;
        end else begin
          r_shift <= {r_shift[23:0], byte_in};
          r_idx   <= r_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for instruction RAM. Reads a 16-bit word
// count (MSB first) then N*4 bytes, writes big-endian words to addresses
// 0..N-1 and holds the CPU in reset until the image is complete.
// Optional macro IMEM_LOADER_CHECKSUM_EN: trailing XOR checksum byte (CHK).
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   start                     begin a load (IDLE, DONE or ERR only)
//   rx_data/rx_valid/rx_ready byte stream handshake
//   mem_we/mem_addr/mem_wdata instruction RAM write port
//   cpu_reset_n               CPU reset, high only once loaded
//   busy/done/error           status
//   word_count                words written in the current load
// ADDR_W must be below LEN_W (16) so MAX_WORDS fits the length field.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
  localparam int unsigned CNT_W     = ADDR_W + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t ST_AFTER_DATA = ST_CHK;
`else
  localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [7:0]        r_len_hi;
  logic [LEN_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_word_count;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_reset_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic             w_accept;
  logic             w_clear;
  logic             w_pack_en;
  logic             w_last_byte;
  logic             w_last_word;
  logic [LEN_W-1:0] w_len_full;
  logic [31:0]      w_word;
  logic             w_word_valid;

  assign w_accept    = rx_valid && r_busy;
  assign w_len_full  = {r_len_hi, rx_data};
  // True when the word being completed is the final one of the image.
  assign w_last_word = (LEN_W'(r_word_count) + LEN_W'(1)) == r_len;

  byte_packer u_packer (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (w_clear),
    .byte_en     (w_pack_en),
    .byte_in     (rx_data),
    .word        (w_word),
    .word_valid  (w_word_valid),
    .last_byte_c (w_last_byte)
  );

  // Next-state and stream-control decode.
  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_pack_en = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_LEN_HI;
          w_clear = 1'b1;
        end
      end
      ST_LEN_HI: begin
        if (w_accept) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) begin
          if (w_len_full == '0)                         w_next = ST_AFTER_DATA;
          else if (w_len_full > LEN_W'(MAX_WORDS))      w_next = ST_ERR;
          else                                          w_next = ST_DATA;
        end
      end
      ST_DATA: begin
        w_pack_en = w_accept;
        if (w_last_byte && w_last_word) w_next = ST_AFTER_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_accept) w_next = (rx_data == r_xor) ? ST_DONE : ST_ERR;
      end
`endif
      ST_DONE, ST_ERR: begin
        if (start) begin
          w_next  = ST_LEN_HI;
          w_clear = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register and registered status/datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_len_hi      <= '0;
      r_len         <= '0;
      r_word_count  <= '0;
      r_mem_addr    <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_cpu_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_xor         <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_busy  <= is_busy(w_next);
      // done/error follow state entry by one cycle and drop on the start edge.
      r_done        <= (r_state == ST_DONE) && (w_next == ST_DONE);
      r_cpu_reset_n <= (r_state == ST_DONE) && (w_next == ST_DONE);
      r_error       <= (r_state == ST_ERR)  && (w_next == ST_ERR);
      if (r_state == ST_LEN_HI && w_accept) r_len_hi <= rx_data;
      if (r_state == ST_LEN_LO && w_accept) r_len    <= w_len_full;
      if (w_clear) begin
        r_word_count <= '0;
      end else if (w_last_byte) begin
        r_word_count <= r_word_count + CNT_W'(1);
        r_mem_addr   <= r_word_count[ADDR_W-1:0];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (w_clear)        r_xor <= '0;
      else if (w_pack_en) r_xor <= r_xor ^ rx_data;
`endif
    end
  end

  assign rx_ready    = r_busy;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign cpu_reset_n = r_cpu_reset_n;
  assign mem_we      = w_word_valid;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = w_word;
  assign word_count  = r_word_count;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for instruction RAM; it is the write-side counterpart of the CPU's read-only instruction fetch.
- Receives a byte stream over a valid/ready interface, packs the bytes into 32-bit big-endian instruction words and writes them to sequential word addresses of a synchronous-write instruction RAM.
- Holds the CPU in reset until the image is completely loaded, then releases it so execution starts at PC 0.
- Sits in Top between the host byte link and the instruction RAM write port; it also drives the CPU reset.

Parameters:
- ADDR_W, 8, instruction RAM word-address width; MAX_WORDS = 2**ADDR_W.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction RAM write strobe, one cycle per word
- mem_addr  out  ADDR_W  word address (byte address >> 2)
- mem_wdata  out  32  instruction word
- cpu_reset_n  out  1  reset to the CPU; high only in DONE
- busy  out  1  state is LEN_HI, LEN_LO, DATA or CHK
- done  out  1  image loaded, CPU running
- error  out  1  length or checksum fault
- word_count  out  ADDR_W+1  words written in the current load

Behaviour:
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR. CHK exists only with the optional feature.
- Reset, asynchronous: state IDLE; all outputs 0, including cpu_reset_n=0; partial word and counters cleared. Reset mid-load discards the partial image; RAM contents already written are not scrubbed.
- Handshake: a byte transfers on a clock edge where rx_valid && rx_ready.
  - rx_ready=1 in LEN_HI, LEN_LO, DATA and CHK; 0 elsewhere.
  - rx_valid while rx_ready=0 is ignored and no byte is consumed.
- IDLE: start -> LEN_HI. word_count and the byte index are cleared.
- LEN_HI: the accepted byte becomes N[15:8]. LEN_LO: the accepted byte becomes N[7:0].
- After LEN_LO:
  - N==0 -> DONE (CHK if enabled).
  - N>MAX_WORDS -> ERR.
  - otherwise -> DATA.
- DATA:
  - byte index 0..3 maps to wdata[31:24], [23:16], [15:8], [7:0].
  - On the 4th byte handshake, next cycle: mem_we=1 for exactly one cycle, mem_addr = current word index, mem_wdata = packed word; word_count increments on that same edge.
  - Write latency is 1 cycle after the last byte. Back-to-back words are allowed; rx_ready stays 1.
  - When word_count reaches N -> DONE (CHK if enabled), in the cycle the last write is issued.
- mem_addr holds its last value when mem_we=0; mem_wdata likewise. mem_addr never wraps because N<=MAX_WORDS.
- DONE: done=1 and cpu_reset_n=1, both registered, asserted the cycle after DONE is entered. Remains until reset or start.
- start in DONE or ERR: cpu_reset_n drops to 0 on the next edge; done and error clear; state -> LEN_HI. start in any busy state is ignored.
- ERR: error=1, cpu_reset_n=0, rx_ready=0; leaves only on start or reset.
- busy and done are mutually exclusive; so are done and error.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - a running XOR of every DATA byte is kept (cleared on start);
  - after the last word, state CHK accepts one byte; match -> DONE, mismatch -> ERR;
  - words already written are not rolled back.
- Without the macro: the CHK state and the XOR register are absent, and the last word (or N==0) goes directly to DONE.

Decomposition:
- Package imem_loader_pkg: state enum loader_state_t; constants LEN_BYTES=2, BYTES_PER_WORD=4.
- Sub-module byte_packer: a 2-bit byte index plus a 32-bit shift register.
  - Interface: byte_in and byte_en in; word and word_valid out (one-cycle pulse); clear in.
  - Clocked by the same clock and reset_n.

Test Plan:
- Reset, then start, then bytes 00 02 | 3C 02 00 12 | 34 42 00 2C -> mem_we pulses twice: addr 0 = 0x3C020012 and addr 1 = 0x3442002C, each one cycle after its 4th byte; done=1 and cpu_reset_n=1 one cycle after the last write; word_count=2.
- Same stream with rx_valid toggled 1/0 every cycle -> identical writes and done timing relative to the last accepted byte; no byte lost or duplicated.
- Length bytes 01 01 (257) with ADDR_W=8 -> ERR, error=1, rx_ready=0, no mem_we.
- Length 00 00 -> DONE without any mem_we; word_count=0.
- reset_n pulsed low after 6 data bytes of a 3-word load -> IDLE, cpu_reset_n=0, word_count=0; a subsequent full load rewrites from addr 0.
- With IMEM_LOADER_CHECKSUM_EN: 1 word FC 80 00 00 and checksum byte 7C -> DONE; checksum byte 00 -> ERR with cpu_reset_n held 0.
